// File: rtl/updown_game_ctrl_if.sv
// Signal bundle between the up/down game controller, the keypad/secret
// front end, the combinational compare block and the display/hint logic.
interface updown_game_ctrl_if;
  logic       start;
  logic       load_secret;
  logic [6:0] secret_in;
  logic [6:0] guess_in;
  logic       guess_valid;
  logic       guess_ready;
  logic [6:0] cmp_actual;
  logic [6:0] cmp_guess;
  logic [1:0] cmp_result;
  logic [1:0] hint;
  logic       hint_valid;
  logic [3:0] tries;
  logic       win;
  logic       lose;
  logic       busy;

  // Environment side: front end, compare block and display/hint consumers.
  modport master (
    output start, load_secret, secret_in, guess_in, guess_valid, cmp_result,
    input  guess_ready, cmp_actual, cmp_guess, hint, hint_valid, tries,
           win, lose, busy
  );

  // Controller side.
  modport slave (
    input  start, load_secret, secret_in, guess_in, guess_valid, cmp_result,
    output guess_ready, cmp_actual, cmp_guess, hint, hint_valid, tries,
           win, lose, busy
  );
endinterface

// File: rtl/updown_game_ctrl.sv
// Up/down guessing-game sequencer: chooses the secret, feeds guesses to the
// external compare block, samples its verdict, counts tries, declares win/lose.
module updown_game_ctrl #(
  parameter int NUM_MAX   = 99,
  parameter int MAX_TRIES = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  updown_game_ctrl_if.slave    bus
);

  localparam logic [6:0] NUM_MAX_C   = 7'(NUM_MAX);
  localparam logic [3:0] MAX_TRIES_C = 4'(MAX_TRIES);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_CHECK = 3'd2,
    ST_WIN   = 3'd3,
    ST_LOSE  = 3'd4
  } state_t;

  state_t     state_r;
  state_t     next_state_s;
  logic [6:0] sec_cnt_r;
  logic [6:0] secret_sel_s;
  logic [3:0] tries_inc_s;
  logic [6:0] cmp_actual_r;
  logic [6:0] cmp_guess_r;
  logic [1:0] hint_r;
  logic       hint_valid_r;
  logic [3:0] tries_r;
  logic       guess_ready_r;
  logic       busy_r;
  logic       win_r;
  logic       lose_r;

  // Status flags {guess_ready, busy, win, lose} implied by a state; registered
  // against the next state so they line up exactly with state_r.
  function automatic logic [3:0] state_flags(input state_t s);
    logic [3:0] f;
    case (s)
      ST_WAIT:  f = 4'b1100;
      ST_CHECK: f = 4'b0100;
      ST_WIN:   f = 4'b0010;
      ST_LOSE:  f = 4'b0001;
      default:  f = 4'b0000;
    endcase
    return f;
  endfunction

  assign tries_inc_s = tries_r + 4'd1;

  // Secret source: an in-range external value, otherwise the running counter.
  always_comb begin
    secret_sel_s = sec_cnt_r;
    if (bus.load_secret && (bus.secret_in <= NUM_MAX_C)) begin
      secret_sel_s = bus.secret_in;
    end else begin
      secret_sel_s = sec_cnt_r;
    end
  end

  // Next-state decode of the game sequence.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (bus.start) begin
          next_state_s = ST_WAIT;
        end else begin
          next_state_s = state_r;
        end
      end
      ST_WAIT: begin
        // Out-of-range guesses are answered in place and do not reach CHECK.
        if (bus.guess_valid && (bus.guess_in <= NUM_MAX_C)) begin
          next_state_s = ST_CHECK;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_CHECK: begin
        if (bus.cmp_result == 2'b00) begin
          next_state_s = ST_WIN;
        end else if (tries_inc_s == MAX_TRIES_C) begin
          next_state_s = ST_LOSE;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register, free-running secret counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      sec_cnt_r     <= 7'd0;
      cmp_actual_r  <= 7'd0;
      cmp_guess_r   <= 7'd0;
      hint_r        <= 2'b00;
      hint_valid_r  <= 1'b0;
      tries_r       <= 4'd0;
      guess_ready_r <= 1'b0;
      busy_r        <= 1'b0;
      win_r         <= 1'b0;
      lose_r        <= 1'b0;
    end else begin
      sec_cnt_r <= (sec_cnt_r == NUM_MAX_C) ? 7'd0 : (sec_cnt_r + 7'd1);
      state_r   <= next_state_s;
      {guess_ready_r, busy_r, win_r, lose_r} <= state_flags(next_state_s);
      hint_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_WIN, ST_LOSE: begin
          if (bus.start) begin
            cmp_actual_r <= secret_sel_s;
            tries_r      <= 4'd0;
          end else begin
            cmp_actual_r <= cmp_actual_r;
          end
        end
        ST_WAIT: begin
          if (bus.guess_valid && (bus.guess_in > NUM_MAX_C)) begin
            hint_r       <= 2'b11;
            hint_valid_r <= 1'b1;
          end else if (bus.guess_valid) begin
            cmp_guess_r  <= bus.guess_in;
          end else begin
            cmp_guess_r  <= cmp_guess_r;
          end
        end
        ST_CHECK: begin
          // The compare block has had the whole CHECK cycle to settle.
          hint_r       <= bus.cmp_result;
          hint_valid_r <= 1'b1;
          tries_r      <= tries_inc_s;
        end
        default: begin
          hint_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.guess_ready = guess_ready_r;
  assign bus.busy        = busy_r;
  assign bus.win         = win_r;
  assign bus.lose        = lose_r;
  assign bus.cmp_actual  = cmp_actual_r;
  assign bus.cmp_guess   = cmp_guess_r;
  assign bus.hint        = hint_r;
  assign bus.hint_valid  = hint_valid_r;
  assign bus.tries       = tries_r;

endmodule

// File: tb/tb_updown_game_ctrl.sv
// Scoreboard bench for updown_game_ctrl with a behavioural compare block.
module tb_updown_game_ctrl;

  typedef struct {
    logic [1:0] hint;
    logic [3:0] tries;
    logic       win;
    logic       lose;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] tb_sec_cnt = 7'd0;
  logic [6:0] tb_secret = 7'd0;
  logic [3:0] tb_tries = 4'd0;
  logic       prev_hv = 1'b0;
  int         n_cmp = 0;
  int         n_err = 0;
  exp_t       exp_q[$];

  updown_game_ctrl_if bus();

  updown_game_ctrl #(.NUM_MAX(99), .MAX_TRIES(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural model of the external compare block.
  always_comb begin
    if (bus.cmp_guess == bus.cmp_actual)     bus.cmp_result = 2'b00;
    else if (bus.cmp_guess > bus.cmp_actual) bus.cmp_result = 2'b01;
    else                                     bus.cmp_result = 2'b10;
  end

  // Reference copy of the secret counter.
  always @(posedge clk) begin
    if (!rst_n)                  tb_sec_cnt <= 7'd0;
    else if (tb_sec_cnt == 7'd99) tb_sec_cnt <= 7'd0;
    else                         tb_sec_cnt <= tb_sec_cnt + 7'd1;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Output side of the scoreboard: every hint pulse is matched to a queued entry.
  always @(negedge clk) begin
    if (rst_n && bus.hint_valid) begin
      check_eq("hv_single", prev_hv, 0);
      if (exp_q.size() == 0) begin
        check_eq("spurious_hint", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("hint",  bus.hint,  e.hint);
        check_eq("tries", bus.tries, e.tries);
        check_eq("win",   bus.win,   e.win);
        check_eq("lose",  bus.lose,  e.lose);
      end
    end
    prev_hv = rst_n && bus.hint_valid;
  end

  task automatic push_exp(input logic [6:0] g);
    exp_t e;
    if (g > 7'd99) begin
      e.hint = 2'b11; e.tries = tb_tries; e.win = 1'b0; e.lose = 1'b0;
    end else begin
      tb_tries = tb_tries + 4'd1;
      e.hint  = (g == tb_secret) ? 2'b00 : ((g > tb_secret) ? 2'b01 : 2'b10);
      e.tries = tb_tries;
      e.win   = (g == tb_secret);
      e.lose  = (g != tb_secret) && (tb_tries == 4'd7);
    end
    exp_q.push_back(e);
  endtask

  task automatic start_game(input logic ld, input logic [6:0] sin);
    bus.start = 1'b1; bus.load_secret = ld; bus.secret_in = sin;
    tb_secret = (ld && sin <= 7'd99) ? sin : tb_sec_cnt;
    tb_tries  = 4'd0;
    @(negedge clk);
    bus.start = 1'b0; bus.load_secret = 1'b0;
    check_eq("start_actual", bus.cmp_actual, tb_secret);
    check_eq("start_busy",   bus.busy, 1);
    check_eq("start_ready",  bus.guess_ready, 1);
    check_eq("start_tries",  bus.tries, 0);
    check_eq("start_flags",  {bus.win, bus.lose, bus.hint_valid}, 0);
  endtask

  task automatic do_guess(input logic [6:0] g);
    check_eq("guess_ready", bus.guess_ready, 1);
    bus.guess_in = g; bus.guess_valid = 1'b1;
    push_exp(g);
    @(negedge clk);
    bus.guess_valid = 1'b0;
    if (g <= 7'd99) @(negedge clk);
    #1;
    check_eq("hint_latency", exp_q.size(), 0);
  endtask

  initial begin
    bus.start = 1'b0; bus.load_secret = 1'b0; bus.secret_in = 7'd0;
    bus.guess_in = 7'd0; bus.guess_valid = 1'b0;

    // Reset and forced secret
    repeat (3) @(negedge clk);
    check_eq("rst_busy",   bus.busy, 0);
    check_eq("rst_ready",  bus.guess_ready, 0);
    check_eq("rst_flags",  {bus.win, bus.lose, bus.hint_valid}, 0);
    check_eq("rst_actual", bus.cmp_actual, 0);
    check_eq("rst_tries",  bus.tries, 0);
    rst_n = 1'b1;
    start_game(1'b1, 7'd42);

    // Correct first guess, then a guess in WIN must be ignored
    do_guess(7'd42);
    check_eq("win1", bus.win, 1);
    check_eq("win1_busy", bus.busy, 0);
    bus.guess_in = 7'd42; bus.guess_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.guess_valid = 1'b0;
    check_eq("win_hold", bus.win, 1);
    check_eq("win_tries_hold", bus.tries, 1);

    // Up/down sequence
    start_game(1'b1, 7'd42);
    do_guess(7'd85);
    do_guess(7'd21);
    do_guess(7'd42);
    check_eq("seq_tries", bus.tries, 3);
    check_eq("seq_win", bus.win, 1);

    // Range check and exhaustion
    start_game(1'b1, 7'd42);
    do_guess(7'd120);
    check_eq("oor_tries", bus.tries, 0);
    check_eq("oor_ready", bus.guess_ready, 1);
    repeat (7) do_guess(7'd10);
    check_eq("lose", bus.lose, 1);
    check_eq("lose_tries", bus.tries, 7);
    check_eq("lose_ready", bus.guess_ready, 0);
    start_game(1'b1, 7'd42);

    // start in WAIT_GUESS is ignored
    bus.start = 1'b1; bus.load_secret = 1'b1; bus.secret_in = 7'd7;
    @(negedge clk);
    bus.start = 1'b0; bus.load_secret = 1'b0;
    check_eq("start_in_wait", bus.cmp_actual, 42);
    do_guess(7'd42);

    // Out-of-range external secret falls back to the counter
    start_game(1'b1, 7'd100);
    check_eq("fallback_actual", bus.cmp_actual, tb_sec_cnt - 7'd1 == 7'h7f ? 7'd99 : tb_sec_cnt - 7'd1);

    // start during CHECK is ignored
    bus.guess_in = (tb_secret == 7'd50) ? 7'd51 : 7'd50; bus.guess_valid = 1'b1;
    push_exp(bus.guess_in);
    @(negedge clk);
    bus.guess_valid = 1'b0;
    bus.start = 1'b1; bus.load_secret = 1'b1; bus.secret_in = 7'd7;
    @(negedge clk);
    bus.start = 1'b0; bus.load_secret = 1'b0;
    #1;
    check_eq("check_hint_seen", exp_q.size(), 0);
    check_eq("start_in_check", bus.cmp_actual, tb_secret);
    check_eq("check_busy", bus.busy, 1);

    // Reset during CHECK
    bus.guess_in = (tb_secret == 7'd60) ? 7'd61 : 7'd60; bus.guess_valid = 1'b1;
    @(negedge clk);
    bus.guess_valid = 1'b0;
    rst_n = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_hv",     bus.hint_valid, 0);
    check_eq("mid_rst_busy",   bus.busy, 0);
    check_eq("mid_rst_ready",  bus.guess_ready, 0);
    check_eq("mid_rst_tries",  bus.tries, 0);
    check_eq("mid_rst_actual", bus.cmp_actual, 0);
    check_eq("mid_rst_guess",  bus.cmp_guess, 0);
    check_eq("mid_rst_hint",   bus.hint, 0);
    check_eq("mid_rst_wl",     {bus.win, bus.lose}, 0);
    bus.start = 1'b0;
    rst_n = 1'b1;

    // Counter secret: start 105 cycles after reset release
    repeat (105) @(negedge clk);
    start_game(1'b0, 7'd0);
    check_eq("cnt_wrap", bus.cmp_actual, 5);

    repeat (3) @(negedge clk);
    check_eq("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
